// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage of the 32-bit MIPS core.
//   - memSize encodings
//   - FSM state type
//   - bit positions inside the {regWrite, memToReg} WB field
//   - misalignment predicate, shared by the lane aligner and anything else that needs it
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // A half access needs addr[0]=0. A word access needs addr[1:0]=0.
    // The reserved size never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling for the data-memory port (little-endian).
// Ports:
//   addr_lo_i   low two address bits (lane select)
//   size_i      access size (byte/half/word/reserved)
//   unsigned_i  zero-extend loads instead of sign-extending them
//   wdata_i     store data from rt
//   rdata_i     buffered word read from memory
//   wdata_o     store data replicated to every lane
//   be_o        byte enables of the addressed lanes
//   rdata_o     selected lane, extended to 32 bits
//   misalign_o  the access is misaligned or uses the reserved size
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sx;
    logic        half_sx;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    assign byte_sx = ~unsigned_i & byte_sel[7];
    assign half_sx = ~unsigned_i & half_sel[15];

    always_comb begin
        wdata_o = wdata_i;
        be_o    = 4'b1111;
        rdata_o = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                be_o    = 4'b0001 << addr_lo_i;
                rdata_o = {{24{byte_sx}}, byte_sel};
            end
            SIZE_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                rdata_o = {{16{half_sx}}, half_sel};
            end
            default: ;
        endcase
    end

    assign misalign_o = is_misaligned(size_i, addr_lo_i);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 32-bit MIPS core, between EX_MEM and MEM_WB.
// Runs a req/ack handshake with a variable-latency data memory for loads and
// stores, stalls the upstream stages while an access is outstanding, and
// presents the extended load data plus pass-through fields to MEM_WB.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   aluResult/writeData   address (or ALU result) and store data from EX_MEM
//   destReg, WB           write-back register and {regWrite, memToReg}
//   memRead/memWrite      load / store request (mutually exclusive)
//   memSize, memUnsigned  access size and load extension mode
//   memReq/memWe/memAddr/memWdata/memBe/memRdata/memAck   data-memory port
//   stall                 hold EX_MEM and earlier stages
//   readData, aluResultOut, destRegOut, WBOut             to MEM_WB
//   excMisalign, excBusErr                                one-cycle exception pulses
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] aluResult,
    input  logic [31:0] writeData,
    input  logic [4:0]  destReg,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memSize,
    input  logic        memUnsigned,
    input  logic [1:0]  WB,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    output logic        stall,
    output logic [31:0] readData,
    output logic [31:0] aluResultOut,
    output logic [4:0]  destRegOut,
    output logic [1:0]  WBOut,
    output logic        excMisalign,
    output logic        excBusErr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ldbuf_q, ldbuf_d;
    logic          err_q, err_d;

    logic          mem_op;
    logic          misalign;
    logic [31:0]   wdata_rep;
    logic [3:0]    be_lanes;
    logic [31:0]   load_ext;

    logic          req_c;
    logic          stall_c;
    logic [1:0]    wb_c;
    logic          mis_c;
    logic          buserr_c;
    logic [31:0]   rd_c;

    mem_lane_align u_align (
        .addr_lo_i  (aluResult[1:0]),
        .size_i     (memSize),
        .unsigned_i (memUnsigned),
        .wdata_i    (writeData),
        .rdata_i    (ldbuf_q),
        .wdata_o    (wdata_rep),
        .be_o       (be_lanes),
        .rdata_o    (load_ext),
        .misalign_o (misalign)
    );

    assign mem_op = memRead | memWrite;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ldbuf_d  = ldbuf_q;
        err_d    = err_q;
        req_c    = 1'b0;
        stall_c  = 1'b0;
        wb_c     = WB;
        mis_c    = 1'b0;
        buserr_c = 1'b0;
        rd_c     = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_op) begin
                    wb_c = 2'b00;
                    if (misalign) begin
                        mis_c = 1'b1;
                    end else begin
                        req_c   = 1'b1;
                        stall_c = 1'b1;
                        err_d   = 1'b0;
                        // The issue cycle already counts toward the timeout.
                        cnt_d   = CW'(1);
                        // A zero-wait memory may acknowledge in the issue cycle.
                        if (memAck) begin
                            if (memRead) ldbuf_d = memRdata;
                            state_d = RESP;
                        end else begin
                            state_d = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                wb_c    = 2'b00;
                cnt_d   = cnt_q + CW'(1);
                if (memAck) begin
                    if (memRead) ldbuf_d = memRdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
                if (err_q) begin
                    wb_c     = 2'b00;
                    buserr_c = 1'b1;
                end else if (memRead) begin
                    rd_c = load_ext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ldbuf_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldbuf_q <= ldbuf_d;
            err_q   <= err_d;
        end
    end

    // Reset masks the combinational outputs so an in-flight request drops at once,
    // even if EX_MEM is still presenting a memory operation.
    assign memReq       = req_c & ~reset;
    assign memWe        = req_c & memWrite & ~reset;
    assign memBe        = (req_c & ~reset) ? be_lanes : 4'b0000;
    assign memAddr      = {aluResult[31:2], 2'b00};
    assign memWdata     = wdata_rep;
    assign stall        = stall_c & ~reset;
    assign WBOut        = reset ? 2'b00 : wb_c;
    assign excMisalign  = mis_c & ~reset;
    assign excBusErr    = buserr_c & ~reset;
    assign readData     = rd_c;
    assign aluResultOut = aluResult;
    assign destRegOut   = destReg;

endmodule
